hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core.
- Reads the M- and W-stage control state back toward D/E: RdM/RegWriteM, RdW/RegWriteW and ResultSrcE.
- Drives operand forwarding into E, load-use stalls, and branch flushes.
- Contains a sequential memory-wait FSM that freezes F..M and bubbles W while data memory is not ready, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, number of consecutive wait cycles after which MemErr is raised.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5 each  source registers in D
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in E
- ResultSrcE  in  2  01 means the instruction in E is a load
- PCSrcE  in  1  branch/jump taken in E
- RdM  in  5  destination register in M
- RegWriteM  in  1  M-stage instruction writes the register file
- MemReqM  in  1  M-stage instruction is accessing data memory
- MemReadyM  in  1  data memory completes the access this cycle
- RdW  in  5  destination register in W
- RegWriteW  in  1  W-stage instruction writes the register file
- ForwardAE, ForwardBE  out  2 each  E operand select: 00 register file, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register
- FlushD, FlushE  out  1 each  clear the D/E pipeline register to a bubble
- FlushW  out  1  clear the M/W register to a bubble
- MemErr  out  1  sticky memory-timeout error

Behaviour:
- Reset (synchronous, active-high; sampled at the clock edge):
  - FSM goes to IDLE; wait counter = 0; MemErr = 0.
  - While reset is high: all stalls 0, FlushD = FlushE = FlushW = 1, ForwardAE = ForwardBE = 00.
- Forwarding (combinational, same cycle), A operand:
  - 10 if RegWriteM && RdM != 0 && RdM == Rs1E;
  - else 01 if RegWriteW && RdW != 0 && RdW == Rs1E;
  - else 00.
  - M beats W when both match. B operand is identical using Rs2E.
- Load-use stall: lwStall = (ResultSrcE == 01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - lwStall drives StallF = StallD = 1 and FlushE = 1.
- Branch flush: PCSrcE drives FlushD = FlushE = 1.
- Memory FSM states: IDLE, WAIT, ERR.
  - memStall in IDLE: asserted combinationally when MemReqM && !MemReadyM, so the stall takes effect in the first miss cycle.
  - IDLE -> WAIT when MemReqM && !MemReadyM; counter loads 1.
  - WAIT: memStall = 1 and the counter increments each cycle.
  - WAIT -> IDLE in the cycle MemReadyM = 1; memStall deasserts in that same cycle and the counter clears.
  - WAIT -> ERR when the counter reaches MEM_TIMEOUT - 1 and MemReadyM = 0.
  - MemReadyM arriving in the same cycle as the timeout wins: the FSM returns to IDLE.
  - ERR: MemErr = 1 and memStall = 1 permanently; only reset exits ERR.
- memStall effect: StallF = StallD = StallE = StallM = 1 and FlushW = 1, so the held M instruction is not committed twice.
- Priority when memStall is high:
  - FlushD and FlushE are forced 0; the taken branch or load-use in E is held and re-evaluated after release.
  - lwStall is masked.
- Priority otherwise: lwStall and PCSrcE together give StallF = StallD = 1 and FlushD = FlushE = 1; the flush of D overrides the stall.
- Reset during WAIT or ERR: FSM returns to IDLE on that edge, and MemErr clears.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds saturating counters of CNT_W bits, each with an output port:
  - LoadUseCnt: cycles with lwStall effective.
  - MemStallCnt: cycles with memStall.
  - FlushCnt: cycles with FlushE caused by PCSrcE.
- Counters clear on reset, increment one per cycle, and hold at all-ones.
- When undefined, the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- hazard_pkg holds:
  - enum fwd_sel_t: FWD_RF = 00, FWD_W = 01, FWD_M = 10.
  - enum mem_state_t: IDLE, WAIT, ERR.
  - constant RESULTSRC_LOAD = 2'b01.
  - constant REG_ZERO = 5'd0.
- One sub-module is natural: hazard_perf_counters, instantiated only under HAZARD_PERF_EN.

Test Plan:
- Forwarding priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set Rd = 0 -> 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly one cycle. Same stimulus with RdE = 0 -> no stall.
- Branch: PCSrcE = 1 -> FlushD = FlushE = 1, stalls 0. Branch plus load-use together -> FlushD = FlushE = 1 and StallF = 1.
- Memory wait: MemReqM = 1, MemReadyM low for 3 cycles then high -> StallF/D/E/M and FlushW high for exactly 3 cycles. With PCSrcE = 1 throughout -> FlushD/E stay 0 for 3 cycles, then assert.
- Timeout: MEM_TIMEOUT = 4, MemReadyM never asserted -> MemErr rises after 4 wait cycles and stays high. Reset -> MemErr = 0, stalls 0.
- With HAZARD_PERF_EN: 3-cycle memory wait plus one load-use -> MemStallCnt = 3, LoadUseCnt = 1. Force CNT_W = 2 and exceed the limit -> counter saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and forwarding helper for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
  localparam logic [4:0] REG_ZERO       = 5'd0;

  // M result is younger than W, so it takes priority when both match
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic reg_write_m,
                                          input logic [4:0] rd_w, input logic reg_write_w);
    if (reg_write_m && rd_m != REG_ZERO && rd_m == rs) return FWD_M;
    if (reg_write_w && rd_w != REG_ZERO && rd_w == rs) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_ctrl_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic [4:0] RdM;
  logic       RegWriteM, MemReqM, MemReadyM;
  logic [4:0] RdW;
  logic       RegWriteW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic       MemErr;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemReadyM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemErr
  );
endinterface

// File: rtl/hazard_perf_counters.sv
// rtl/hazard_perf_counters.sv - saturating hazard event counters
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             mem_stall,
  input  logic             br_flush,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      load_use_cnt  <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (load_use && !(&load_use_cnt))   load_use_cnt  <= load_use_cnt + CNT_W'(1);
      if (mem_stall && !(&mem_stall_cnt)) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
      if (br_flush && !(&flush_cnt))      flush_cnt     <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use/branch hazards and memory-wait FSM
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] LoadUseCnt
  , output logic [CNT_W-1:0] MemStallCnt
  , output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

  mem_state_t    state, state_n;
  logic [TW-1:0] wcnt, wcnt_n;
  logic          mem_stall, lw_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    case (state)
      IDLE: if (hz.MemReqM && !hz.MemReadyM) begin
        state_n = WAIT;
        wcnt_n  = TW'(1);
      end
      // a ready response arriving on the timeout cycle still completes normally
      WAIT: if (hz.MemReadyM) begin
        state_n = IDLE;
        wcnt_n  = '0;
      end else if (wcnt >= T_LAST) begin
        state_n = ERR;
      end else begin
        wcnt_n = wcnt + TW'(1);
      end
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    mem_stall = hz.MemReqM && !hz.MemReadyM;
      WAIT:    mem_stall = !hz.MemReadyM;
      default: mem_stall = 1'b1;
    endcase

    lw_stall = (hz.ResultSrcE == RESULTSRC_LOAD) && (hz.RdE != REG_ZERO) &&
               (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

    hz.MemErr = (state == ERR);

    if (reset) begin
      hz.ForwardAE = FWD_RF;
      hz.ForwardBE = FWD_RF;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.StallM    = 1'b0;
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.FlushW    = 1'b1;
    end else begin
      hz.ForwardAE = fwd_select(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      hz.ForwardBE = fwd_select(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      // a memory freeze holds E intact, so branch/load-use are re-evaluated afterwards
      hz.StallF    = mem_stall || lw_stall;
      hz.StallD    = mem_stall || lw_stall;
      hz.StallE    = mem_stall;
      hz.StallM    = mem_stall;
      hz.FlushD    = !mem_stall && hz.PCSrcE;
      hz.FlushE    = !mem_stall && (hz.PCSrcE || lw_stall);
      hz.FlushW    = mem_stall;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .reset         (reset),
    .load_use      (lw_stall && !mem_stall),
    .mem_stall     (mem_stall),
    .br_flush      (hz.PCSrcE && !mem_stall),
    .load_use_cnt  (LoadUseCnt),
    .mem_stall_cnt (MemStallCnt),
    .flush_cnt     (FlushCnt)
  );
`endif

endmodule
